// File: rtl/yadmc_dpram_arb.sv
// Two-requester arbiter in front of one port of a dual-port RAM.
// Each access takes IDLE -> ISSUE -> WAIT -> ACK; simultaneous requests alternate round-robin.
module yadmc_dpram_arb #(
  parameter int address_depth = 10,
  parameter int data_width    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [address_depth-1:0] m0_adr,
  input  logic [data_width-1:0]    m0_di,
  output logic                     m0_ack,
  output logic [data_width-1:0]    m0_do,

  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [address_depth-1:0] m1_adr,
  input  logic [data_width-1:0]    m1_di,
  output logic                     m1_ack,
  output logic [data_width-1:0]    m1_do,

  output logic [address_depth-1:0] ram_adr,
  output logic                     ram_we,
  output logic [data_width-1:0]    ram_di,
  input  logic [data_width-1:0]    ram_do,

  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                   state_reg, state_next;
  logic                     grant_reg, grant_next;
  logic                     last_grant_reg, last_grant_next;
  logic [address_depth-1:0] ram_adr_reg, ram_adr_next;
  logic                     ram_we_reg, ram_we_next;
  logic [data_width-1:0]    ram_di_reg, ram_di_next;
  logic                     m0_ack_reg, m0_ack_next;
  logic                     m1_ack_reg, m1_ack_next;
  logic [data_width-1:0]    m0_do_reg, m0_do_next;
  logic [data_width-1:0]    m1_do_reg, m1_do_next;
  logic                     pick;

  // On a tie the requester that did not win last time is chosen.
  assign pick = (m0_req && m1_req) ? ~last_grant_reg : m1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      ram_adr_reg    <= '0;
      ram_we_reg     <= 1'b0;
      ram_di_reg     <= '0;
      m0_ack_reg     <= 1'b0;
      m1_ack_reg     <= 1'b0;
      m0_do_reg      <= '0;
      m1_do_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      ram_adr_reg    <= ram_adr_next;
      ram_we_reg     <= ram_we_next;
      ram_di_reg     <= ram_di_next;
      m0_ack_reg     <= m0_ack_next;
      m1_ack_reg     <= m1_ack_next;
      m0_do_reg      <= m0_do_next;
      m1_do_reg      <= m1_do_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    ram_adr_next    = ram_adr_reg;
    ram_we_next     = ram_we_reg;
    ram_di_next     = ram_di_reg;
    m0_ack_next     = 1'b0;
    m1_ack_next     = 1'b0;
    m0_do_next      = m0_do_reg;
    m1_do_next      = m1_do_reg;

    unique case (state_reg)
      IDLE: begin
        ram_we_next = 1'b0;
        if (m0_req || m1_req) begin
          grant_next      = pick;
          last_grant_next = pick;
          ram_adr_next    = pick ? m1_adr : m0_adr;
          ram_we_next     = pick ? m1_we  : m0_we;
          ram_di_next     = pick ? m1_di  : m0_di;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        ram_we_next = 1'b0;
        state_next  = WAIT;
      end
      WAIT: begin
        // The RAM is write-first, so a write returns the data just stored.
        if (grant_reg) begin
          m1_ack_next = 1'b1;
          m1_do_next  = ram_do;
        end else begin
          m0_ack_next = 1'b1;
          m0_do_next  = ram_do;
        end
        state_next = ACK;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ram_adr = ram_adr_reg;
  assign ram_we  = ram_we_reg;
  assign ram_di  = ram_di_reg;
  assign m0_ack  = m0_ack_reg;
  assign m1_ack  = m1_ack_reg;
  assign m0_do   = m0_do_reg;
  assign m1_do   = m1_do_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_yadmc_dpram_arb.sv
// Bench for yadmc_dpram_arb: write-first RAM model plus a cycle-level reference of
// grant order, ack timing and returned data, checked on every falling edge.
module tb_yadmc_dpram_arb;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [DW-1:0] m0_di = '0, m1_di = '0;
  logic          m0_ack, m1_ack, ram_we, busy;
  logic [DW-1:0] m0_do, m1_do, ram_di;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_do;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 37 + 11);
  endfunction

  // External RAM port: registered, write-first.
  logic [DW-1:0] mem [1<<AW];
  bit            written [1<<AW];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_adr]     <= ram_di;
      written[ram_adr] <= 1'b1;
      ram_do           <= ram_di;
    end else begin
      ram_do <= written[ram_adr] ? mem[ram_adr] : init_val(int'(ram_adr));
    end
  end

  yadmc_dpram_arb #(.address_depth(AW), .data_width(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_di(m0_di), .m0_ack(m0_ack), .m0_do(m0_do),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_di(m1_di), .m1_ack(m1_ack), .m1_do(m1_do),
    .ram_adr(ram_adr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [DW-1:0] di;
    int            nb;   // earliest falling-edge cycle at which req may be raised
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];

  // Reference state: memory contents, arbitration history and the access in flight.
  logic [DW-1:0] ref_mem [1<<AW];
  bit            lg = 1'b1;
  int            idle_from = 0;
  bit            outstanding = 1'b0;
  bit            g = 1'b0;
  int            issue_at = 0, ack_at = 0;
  txn_t          cur;
  logic [DW-1:0] nxt_do = '0, exp_do0 = '0, exp_do1 = '0;

  function automatic txn_t mk(input bit we, input int adr, input int di, input int nb);
    txn_t t;
    t.we  = we;
    t.adr = AW'(adr);
    t.di  = DW'(di);
    t.nb  = nb;
    return t;
  endfunction

  task automatic present(input int n);
    if (q0.size() > 0) begin
      m0_req = (q0[0].nb <= n); m0_we = q0[0].we; m0_adr = q0[0].adr; m0_di = q0[0].di;
    end else m0_req = 1'b0;
    if (q1.size() > 0) begin
      m1_req = (q1[0].nb <= n); m1_we = q1[0].we; m1_adr = q1[0].adr; m1_di = q1[0].di;
    end else m1_req = 1'b0;
  endtask

  task automatic engine(input string tag, input int budget);
    int start;
    bit done, at_issue, e_ack0, e_ack1, gsel;
    start = cyc;
    done  = 1'b0;
    while (!done && (cyc - start) < budget) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'(cyc < idle_from));
      at_issue = outstanding && (cyc == issue_at);
      e_ack0   = outstanding && (cyc == ack_at) && !g;
      e_ack1   = outstanding && (cyc == ack_at) && g;
      if (e_ack0) exp_do0 = nxt_do;
      if (e_ack1) exp_do1 = nxt_do;
      check({tag, "_m0_ack"}, 32'(m0_ack), 32'(e_ack0));
      check({tag, "_m1_ack"}, 32'(m1_ack), 32'(e_ack1));
      check({tag, "_m0_do"}, 32'(m0_do), 32'(exp_do0));
      check({tag, "_m1_do"}, 32'(m1_do), 32'(exp_do1));
      check({tag, "_ram_we"}, 32'(ram_we), 32'(at_issue && cur.we));
      if (at_issue) begin
        check({tag, "_ram_adr"}, 32'(ram_adr), 32'(cur.adr));
        check({tag, "_ram_di"}, 32'(ram_di), 32'(cur.di));
      end
      if (e_ack0 || e_ack1) begin
        $display("[TB] %s m%0d %s adr=%h do=%h", tag, g, cur.we ? "wr" : "rd", cur.adr,
                 g ? m1_do : m0_do);
        outstanding = 1'b0;
        if (e_ack1) q1.delete(0); else q0.delete(0);
      end
      present(cyc);
      if (!outstanding && cyc >= idle_from && (m0_req || m1_req)) begin
        gsel        = (m0_req && m1_req) ? !lg : m1_req;
        lg          = gsel;
        g           = gsel;
        cur         = gsel ? q1[0] : q0[0];
        nxt_do      = cur.we ? cur.di : ref_mem[cur.adr];
        if (cur.we) ref_mem[cur.adr] = cur.di;
        issue_at    = cyc + 1;
        ack_at      = cyc + 3;
        idle_from   = cyc + 4;
        outstanding = 1'b1;
      end
      done = !outstanding && q0.size() == 0 && q1.size() == 0;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Pulses rst_n low mid-cycle and checks the immediate reset values.
  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_m0_ack"}, 32'(m0_ack), 32'd0);
    check({tag, "_m1_ack"}, 32'(m1_ack), 32'd0);
    check({tag, "_ram_adr"}, 32'(ram_adr), 32'd0);
    check({tag, "_ram_di"}, 32'(ram_di), 32'd0);
    check({tag, "_m0_do"}, 32'(m0_do), 32'd0);
    check({tag, "_m1_do"}, 32'(m1_do), 32'd0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    q0.delete();
    q1.delete();
    #2 rst_n = 1'b1;
    idle_from   = 0;
    outstanding = 1'b0;
    lg          = 1'b1;
    exp_do0     = '0;
    exp_do1     = '0;
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_val(a);

    // Reset values
    @(negedge clk);
    reset_pulse("reset");

    // Single write then read by m0
    q0.push_back(mk(1'b1, 'h005, 'hA5, 0));
    engine("wr5", 100);
    q0.push_back(mk(1'b0, 'h005, 0, 0));
    engine("rd5", 100);

    // Simultaneous requests straight after reset: m0 first, m1 four cycles later
    @(negedge clk);
    reset_pulse("reset2");
    q0.push_back(mk(1'b0, 'h010, 0, 0));
    q1.push_back(mk(1'b0, 'h020, 0, 0));
    engine("simul", 100);

    // Both requesters busy for 8 accesses: grants alternate
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 0));
      q1.push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 0));
    end
    engine("rr", 200);

    // m1 raises req during the ISSUE cycle of an m0 access
    q0.push_back(mk(1'b0, int'($urandom_range(0, 1023)), 0, 0));
    q1.push_back(mk(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), cyc + 2));
    engine("late", 100);

    // Reset during ISSUE aborts an m1 write to 0x3FF
    q0.push_back(mk(1'b1, 'h3FF, 'h77, 0));
    engine("pre3ff", 100);
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_adr = 10'h3FF; m1_di = 8'h3C;
    @(negedge clk);
    check("abort_issue_we", 32'(ram_we), 32'd1);
    check("abort_issue_busy", 32'(busy), 32'd1);
    reset_pulse("abort");
    q1.push_back(mk(1'b0, 'h3FF, 0, 0));
    engine("rd3ff", 100);

    // m1 keeps req high across two queued writes
    q1.push_back(mk(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 0));
    q1.push_back(mk(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 0));
    engine("b2b", 100);

    // Random mix of requesters, directions and request times
    for (int i = 0; i < 24; i++) begin
      txn_t t;
      t = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)),
             cyc + int'($urandom_range(0, 40)));
      if ($urandom_range(0, 1) == 1) q1.push_back(t); else q0.push_back(t);
    end
    engine("rand", 600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/yadmc_dpram_arb.md
YADMC_DPRAM_ARB -- requirements
Module: yadmc_dpram_arb

Interface
REQ-001 SHALL have parameter address_depth, default 10, meaning RAM address width in bits.
REQ-002 SHALL have parameter data_width, default 8, meaning RAM data width in bits.
REQ-003 SHALL have clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have m0_req  input  1  requester 0 access request, held until m0_ack.
REQ-006 SHALL have m0_we  input  1  requester 0 write enable (1 write, 0 read), valid with m0_req.
REQ-007 SHALL have m0_adr  input  address_depth  requester 0 address.
REQ-008 SHALL have m0_di  input  data_width  requester 0 write data.
REQ-009 SHALL have m0_ack  output  1  requester 0 one-cycle completion pulse.
REQ-010 SHALL have m0_do  output  data_width  requester 0 read/write-back data, valid while m0_ack high.
REQ-011 SHALL have m1_req, m1_we, m1_adr, m1_di, m1_ack, m1_do with the same directions, widths and meanings for requester 1.
REQ-012 SHALL have ram_adr  output  address_depth  address to one port of the dual-port RAM.
REQ-013 SHALL have ram_we  output  1  write enable to that RAM port.
REQ-014 SHALL have ram_di  output  data_width  write data to that RAM port.
REQ-015 SHALL have ram_do  input  data_width  registered RAM output, write-first, valid one cycle after the access edge.
REQ-016 SHALL have busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL implement a state machine with states IDLE, ISSUE, WAIT, ACK; transitions only on posedge clk.
REQ-018 IDLE: if any req is high at the edge, SHALL latch the grant, register ram_adr/ram_we/ram_di from the granted requester and go to ISSUE; otherwise stay in IDLE with ram_we 0.
REQ-019 ISSUE: the RAM performs the access at the end-of-cycle edge; the block SHALL clear ram_we at that edge and go to WAIT.
REQ-020 WAIT: at the end-of-cycle edge the block SHALL register ram_do into the granted mN_do, set the granted mN_ack to 1 and go to ACK.
REQ-021 ACK: at the end-of-cycle edge the block SHALL clear mN_ack and go to IDLE; ack SHALL be exactly one cycle wide.
REQ-022 Latency: for a req sampled at edge T0, ack SHALL be high during the cycle between edges T2 and T3; one access per 4 cycles maximum.
REQ-023 Requesters SHALL deassert req during the ack cycle; a req still high when IDLE is next reached SHALL be treated as a new access.
REQ-024 Arbitration: if only one req is high, it SHALL be granted; if both are high, the requester other than last_grant SHALL be granted (round-robin).
REQ-025 last_grant SHALL update on every grant; req changes outside IDLE SHALL be ignored.
REQ-026 For a write, mN_do SHALL return the written data, per the RAM's write-first behaviour.
REQ-027 The non-granted requester's ack and do SHALL hold unchanged (ack 0) throughout.
REQ-028 ram_adr and ram_di SHALL hold their last value outside ISSUE; only ram_we qualifies an access.

Reset
REQ-029 On rst_n low, the block SHALL immediately force state IDLE, ram_we 0, m0_ack 0, m1_ack 0, busy 0, ram_adr 0, ram_di 0, m0_do 0, m1_do 0 and last_grant 1, so that m0 wins the first simultaneous request.
REQ-030 Reset asserted during ISSUE SHALL abort the access; no RAM write occurs, because ram_we is already 0 at the edge. No ack SHALL be issued for an aborted access, and requesters SHALL re-request.

Verification
REQ-031 Single write then read: m0 writes adr 0x005 data 0xA5 -> ram_we high exactly one cycle, m0_ack at T2..T3, m0_do 0xA5. Then m0 reads adr 0x005 -> m0_do 0xA5, ram_we stays 0.
REQ-032 Simultaneous requests after reset: m0 reads adr 0x010 and m1 reads adr 0x020, both held -> m0 granted first, m1 granted in the next IDLE, and acks are 4 cycles apart.
REQ-033 Round-robin fairness: both reqs continuously re-asserted for 8 accesses -> grants strictly alternate m0, m1, m0, and so on, with no requester starved.
REQ-034 Ignored late request: m1_req rises during the ISSUE of an m0 access -> m1 is not granted until the next IDLE, and m1_ack stays 0 until then.
REQ-035 Reset mid-access: m1 write to adr 0x3FF data 0x3C, with rst_n pulsed low during ISSUE -> ram_we 0 at once, no ack, state IDLE, and a later read of 0x3FF returns its prior value.
REQ-036 Back-to-back same requester: m1 keeps req high through its ack with 2 queued writes -> the second access starts in the IDLE that follows ACK, and busy drops for exactly one cycle between accesses.
